alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Execute-issue stage directly upstream of the core ALU.
- Accepts decoded instructions over a valid/ready handshake and selects operand B (register or immediate).
- Patches stale register operands from the ALU result forwarding bus.
- Presents registered alu_op, a, b and unsigned_flag to the ALU, with a 2-entry skid buffer so back-pressure never drops an instruction.

Parameters:
- XLEN, 32, operand/result width (ALU is fixed at 32; do not change).
- RADDR_W, 5, register address width.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept; registered.
- in_alu_op  input  4  ALU opcode, passed through unmodified.
- in_unsigned  input  1  unsigned compare flag.
- in_rs1_addr, in_rs2_addr  input  RADDR_W  source register addresses.
- in_rs1_data, in_rs2_data  input  XLEN  register file read data.
- in_imm  input  XLEN  sign-extended immediate.
- in_use_imm  input  1  1: B = in_imm, rs2 ignored.
- in_rd_addr  input  RADDR_W  destination register.
- in_rd_we  input  1  destination write enable.
- fwd_valid  input  1  forwarding bus valid (registered ALU result being written back).
- fwd_rd_addr  input  RADDR_W  forwarding destination.
- fwd_data  input  XLEN  forwarded value.
- out_valid  output  1  ALU operands valid.
- out_ready  input  1  downstream consumes current operands.
- alu_op  output  4  to ALU.
- a, b  output  XLEN  to ALU (signed interpretation downstream).
- unsigned_flag  output  1  to ALU.
- out_rd_addr  output  RADDR_W  destination tag travelling with operands.
- out_rd_we  output  1  destination write enable travelling with operands.
- stall_count  output  STALL_CNT_W  cycles with out_valid and !out_ready, saturating.

Behaviour:
- Reset: out_valid=0, in_ready=1, alu_op/a/b/unsigned_flag/out_rd_addr/out_rd_we=0, stall_count=0, both buffer entries invalid. Reset mid-transfer discards all held instructions.
- Storage: main entry (drives outputs) plus skid entry. Each entry holds op, unsigned, a, b, rs1_addr, rs2_addr, b_is_imm, rd_addr, rd_we, valid.
- Accept when in_valid && in_ready. Latency 1: an instruction accepted in cycle N is on the outputs with out_valid=1 in cycle N+1 if main is empty or being consumed.
- Routing on accept:
  - main empty, or main consumed this cycle with skid empty -> main.
  - otherwise -> skid.
  - When main is consumed and skid is valid, skid moves to main in the same cycle.
- in_ready (registered) = 1 iff skid is empty at the next cycle. Accept while skid full cannot occur; in_valid with in_ready=0 is ignored.
- Ordering strictly FIFO; no bubble inserted when out_ready stays high (throughput 1/cycle).
- Forwarding, capture time: if fwd_valid and fwd_rd_addr==rs1_addr and rs1_addr!=0, captured a=fwd_data. Same for b when b_is_imm=0.
- Forwarding, held entries: every valid entry snoops the forwarding bus each cycle with the same rules and overwrites a/b in place. Outputs therefore change while out_valid=1 and out_ready=0.
- Address 0 is never forwarded. Operand stays as supplied (expected 0).
- in_use_imm=1: b=in_imm, never overwritten by forwarding.
- alu_op is passed through unchanged, including undefined codes; the ALU flags unknown ops.
- stall_count: +1 each cycle out_valid && !out_ready; holds at all-ones.

Test Plan:
- Reset, then in_valid=1, op=ADD, rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, a=5, b=7, alu_op=ADD; in_ready stays 1.
- Back-to-back: 3 instrs with out_ready=0 from the 2nd issue -> main+skid fill, in_ready=0, third held upstream. Then out_ready=1 -> all 3 emerge in order on consecutive cycles, stall_count equals stalled cycles.
- Accept rs1=3, rs1_data=1, fwd_valid=1, fwd_rd_addr=3, fwd_data=0xDEADBEEF same cycle -> a=0xDEADBEEF.
- Held entry rs2=4 with out_ready=0; fwd 4 <- 0x80000000 -> b updates to 0x80000000 while out_valid stays 1.
- in_use_imm=1, imm=0xFFFFFFF0, fwd matching rs2 -> b=0xFFFFFFF0. rs1=0 with fwd_rd_addr=0, fwd_data=9 -> a unchanged (0).
- Two instrs held, assert reset one cycle -> out_valid=0, in_ready=1, stall_count=0; nothing emitted after reset.

Source files
------------

// File: rtl/alu_issue_if.sv
// Operand-issue bus for alu_issue: decoded instruction in, forwarding
// snoop, and registered ALU operands out.
interface alu_issue_if #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int STALL_CNT_W = 16
);
    // Upstream (decode) side
    logic                      in_valid;
    logic                      in_ready;
    logic [3:0]                in_alu_op;
    logic                      in_unsigned;
    logic [RADDR_W-1:0]        in_rs1_addr;
    logic [RADDR_W-1:0]        in_rs2_addr;
    logic [XLEN-1:0]           in_rs1_data;
    logic [XLEN-1:0]           in_rs2_data;
    logic [XLEN-1:0]           in_imm;
    logic                      in_use_imm;
    logic [RADDR_W-1:0]        in_rd_addr;
    logic                      in_rd_we;

    // ALU result forwarding bus
    logic                      fwd_valid;
    logic [RADDR_W-1:0]        fwd_rd_addr;
    logic [XLEN-1:0]           fwd_data;

    // Downstream (ALU) side
    logic                      out_valid;
    logic                      out_ready;
    logic [3:0]                alu_op;
    logic signed [XLEN-1:0]    a;
    logic signed [XLEN-1:0]    b;
    logic                      unsigned_flag;
    logic [RADDR_W-1:0]        out_rd_addr;
    logic                      out_rd_we;
    logic [STALL_CNT_W-1:0]    stall_count;

    // Issue stage side
    modport slave (
        input  in_valid, in_alu_op, in_unsigned, in_rs1_addr, in_rs2_addr,
               in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_rd_addr, in_rd_we,
               fwd_valid, fwd_rd_addr, fwd_data, out_ready,
        output in_ready, out_valid, alu_op, a, b, unsigned_flag,
               out_rd_addr, out_rd_we, stall_count
    );

    // Decode / environment side
    modport master (
        output in_valid, in_alu_op, in_unsigned, in_rs1_addr, in_rs2_addr,
               in_rs1_data, in_rs2_data, in_imm, in_use_imm, in_rd_addr, in_rd_we,
               fwd_valid, fwd_rd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, alu_op, a, b, unsigned_flag,
               out_rd_addr, out_rd_we, stall_count
    );
endinterface

// File: rtl/alu_issue.sv
// Execute-issue stage in front of the ALU. Selects operand B, patches stale
// register operands from the forwarding bus (at capture and while held), and
// presents registered operands through a main entry backed by a skid entry so
// that back-pressure never drops an instruction.
module alu_issue #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus
);

    typedef struct packed {
        logic               vld;
        logic [3:0]         op;
        logic               uns;
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic               b_imm;
        logic [RADDR_W-1:0] rd;
        logic               rd_we;
    } entry_t;

    // Apply one forwarding-bus beat to an entry. Register 0 is hard-wired and
    // never patched; an immediate B operand is never patched.
    function automatic entry_t snoop(
        input entry_t             e,
        input logic               fv,
        input logic [RADDR_W-1:0] fa,
        input logic [XLEN-1:0]    fd
    );
        entry_t r;
        r = e;
        if (e.vld && fv && (fa != '0)) begin
            if (fa == e.rs1)
                r.a = fd;
            if (!e.b_imm && (fa == e.rs2))
                r.b = fd;
        end
        return r;
    endfunction

    // Saturating increment: holds at all-ones.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
        if (&c)
            return c;
        return c + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    entry_t                 r_main;
    entry_t                 r_skid;
    logic                   r_in_ready;
    logic [STALL_CNT_W-1:0] r_stall;

    entry_t                 w_cap;
    entry_t                 w_new;
    entry_t                 w_main_snp;
    entry_t                 w_skid_snp;
    entry_t                 w_main_nxt;
    entry_t                 w_skid_nxt;
    logic                   w_accept;
    logic                   w_consume;

    // Build the incoming entry, snoop held entries, and route main/skid.
    always_comb begin
        w_cap       = '0;
        w_cap.vld   = 1'b1;
        w_cap.op    = bus.in_alu_op;
        w_cap.uns   = bus.in_unsigned;
        w_cap.a     = bus.in_rs1_data;
        w_cap.b     = bus.in_use_imm ? bus.in_imm : bus.in_rs2_data;
        w_cap.rs1   = bus.in_rs1_addr;
        w_cap.rs2   = bus.in_rs2_addr;
        w_cap.b_imm = bus.in_use_imm;
        w_cap.rd    = bus.in_rd_addr;
        w_cap.rd_we = bus.in_rd_we;

        w_new      = snoop(w_cap,  bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data);
        w_main_snp = snoop(r_main, bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data);
        w_skid_snp = snoop(r_skid, bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data);

        w_accept  = bus.in_valid && r_in_ready;
        w_consume = r_main.vld && bus.out_ready;

        w_main_nxt = w_main_snp;
        w_skid_nxt = w_skid_snp;

        if (!r_main.vld || (w_consume && !r_skid.vld)) begin
            // Main is free this cycle: new instruction goes straight to the outputs.
            w_main_nxt = w_accept ? w_new : '0;
            w_skid_nxt = '0;
        end else if (w_consume) begin
            // Skid advances into main; a new instruction (if any) refills skid.
            w_main_nxt = w_skid_snp;
            w_skid_nxt = w_accept ? w_new : '0;
        end else if (w_accept) begin
            // Main is stalled and skid is empty (in_ready was high).
            w_skid_nxt = w_new;
        end
    end

    // Buffer entries and registered ready; reset discards held instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= !w_skid_nxt.vld;
        end
    end

    // Count cycles where the ALU refuses valid operands.
    always_ff @(posedge clk) begin
        if (reset)
            r_stall <= '0;
        else if (r_main.vld && !bus.out_ready)
            r_stall <= sat_inc(r_stall);
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_main.vld;
    assign bus.alu_op        = r_main.op;
    assign bus.a             = r_main.a;
    assign bus.b             = r_main.b;
    assign bus.unsigned_flag = r_main.uns;
    assign bus.out_rd_addr   = r_main.rd;
    assign bus.out_rd_we     = r_main.rd_we;
    assign bus.stall_count   = r_stall;

endmodule

// File: tb/tb_alu_issue.sv
// Scenario bench for alu_issue: expected operand sets are queued when an
// instruction is accepted and compared in order as the ALU consumes them.
module tb_alu_issue;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int SW   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(XLEN), .RADDR_W(RW), .STALL_CNT_W(SW)) bus();

    alu_issue #(.XLEN(XLEN), .RADDR_W(RW), .STALL_CNT_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic        uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    exp_t mon_got;
    exp_t mon_exp;
    int   checks   = 0;
    int   failures = 0;

    // Scoreboard: every consumed operand set must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            mon_got = {bus.alu_op, bus.unsigned_flag, bus.a, bus.b, bus.out_rd_addr, bus.out_rd_we};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got op=%h a=%h b=%h rd=%0d, required no output", mon_got.op, mon_got.a, mon_got.b, mon_got.rd);
            end else begin
                mon_exp = q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL out_data: got op=%h uns=%b a=%h b=%h rd=%0d we=%b, required op=%h uns=%b a=%h b=%h rd=%0d we=%b",
                             mon_got.op, mon_got.uns, mon_got.a, mon_got.b, mon_got.rd, mon_got.we,
                             mon_exp.op, mon_exp.uns, mon_exp.a, mon_exp.b, mon_exp.rd, mon_exp.we);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_alu_op   = 4'h0;
        bus.in_unsigned = 1'b0;
        bus.in_rs1_addr = '0;
        bus.in_rs2_addr = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.in_imm      = '0;
        bus.in_use_imm  = 1'b0;
        bus.in_rd_addr  = '0;
        bus.in_rd_we    = 1'b0;
    endtask

    task automatic present(input logic [3:0] op, input logic uns,
                           input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic use_imm, input logic [31:0] imm,
                           input logic [4:0] rd, input logic we);
        bus.in_valid    = 1'b1;
        bus.in_alu_op   = op;
        bus.in_unsigned = uns;
        bus.in_rs1_addr = rs1;
        bus.in_rs1_data = d1;
        bus.in_rs2_addr = rs2;
        bus.in_rs2_data = d2;
        bus.in_use_imm  = use_imm;
        bus.in_imm      = imm;
        bus.in_rd_addr  = rd;
        bus.in_rd_we    = we;
    endtask

    // Present an instruction until accepted (bounded); queue its expected operands.
    // Entered and left at posedge+1.
    task automatic issue(input logic [3:0] op, input logic uns,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic use_imm, input logic [31:0] imm,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        present(op, uns, rs1, d1, rs2, d2, use_imm, imm, rd, we);
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                q.push_back({op, uns, exp_a, exp_b, rd, we});
                done = 1;
            end else if (n >= 20) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
                done = 1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.fwd_valid   = 1'b0;
        bus.fwd_rd_addr = '0;
        bus.fwd_data    = '0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
        checks++; if (bus.alu_op !== 4'h0) begin failures++; $display("FAIL reset_alu_op: got %h, required 0", bus.alu_op); end
        checks++; if (bus.a !== 32'h0 || bus.b !== 32'h0) begin failures++; $display("FAIL reset_ab: got a=%h b=%h, required 0/0", bus.a, bus.b); end
        checks++; if ({bus.unsigned_flag, bus.out_rd_addr, bus.out_rd_we} !== 7'h0) begin failures++; $display("FAIL reset_tags: got uns=%b rd=%0d we=%b, required 0", bus.unsigned_flag, bus.out_rd_addr, bus.out_rd_we); end
        checks++; if (bus.stall_count !== 16'h0) begin failures++; $display("FAIL reset_stall: got %0d, required 0", bus.stall_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        issue(4'h0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0, 5'd3, 1'b1, 32'd5, 32'd7);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.a !== 32'd5 || bus.b !== 32'd7 || bus.alu_op !== 4'h0) begin
            failures++; $display("FAIL basic_latency: got vld=%b a=%h b=%h op=%h, required 1/5/7/0", bus.out_valid, bus.a, bus.b, bus.alu_op);
        end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready: got %b, required 1", bus.in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain: out_valid=%b, required 0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        issue(4'h1, 1'b0, 5'd1, 32'h11, 5'd2, 32'h12, 1'b0, 32'h0, 5'd5, 1'b1, 32'h11, 32'h12);
        bus.out_ready = 1'b0;
        issue(4'h2, 1'b1, 5'd3, 32'h21, 5'd4, 32'h22, 1'b0, 32'h0, 5'd6, 1'b1, 32'h21, 32'h22);
        for (int i = 0; i < 3; i++) begin
            present(4'h3, 1'b0, 5'd7, 32'h31, 5'd8, 32'h32, 1'b0, 32'h0, 5'd7, 1'b0);
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready[%0d]: got %b, required 0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.alu_op !== 4'h1 || bus.a !== 32'h11) begin
                failures++; $display("FAIL b2b_hold[%0d]: got vld=%b op=%h a=%h, required 1/1/11", i, bus.out_valid, bus.alu_op, bus.a);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        issue(4'h3, 1'b0, 5'd7, 32'h31, 5'd8, 32'h32, 1'b0, 32'h0, 5'd7, 1'b0, 32'h31, 32'h32);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_op !== 4'h3) begin
            failures++; $display("FAIL b2b_third: got vld=%b op=%h, required 1/3", bus.out_valid, bus.alu_op);
        end
        checks++; if (bus.stall_count !== 16'd4) begin failures++; $display("FAIL b2b_stall_count: got %0d, required 4", bus.stall_count); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_back: got %b, required 1", bus.in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: out_valid=%b, required 0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_fwd_capture();
        bus.out_ready   = 1'b1;
        bus.fwd_valid   = 1'b1;
        bus.fwd_rd_addr = 5'd3;
        bus.fwd_data    = 32'hDEADBEEF;
        issue(4'h0, 1'b0, 5'd3, 32'd1, 5'd5, 32'd6, 1'b0, 32'h0, 5'd9, 1'b1, 32'hDEADBEEF, 32'd6);
        issue(4'h4, 1'b0, 5'd2, 32'd4, 5'd3, 32'd8, 1'b0, 32'h0, 5'd10, 1'b1, 32'd4, 32'hDEADBEEF);
        bus.fwd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_fwd_held();
        bus.out_ready = 1'b0;
        issue(4'h5, 1'b0, 5'd6, 32'h11, 5'd4, 32'h22, 1'b0, 32'h0, 5'd10, 1'b1, 32'h11, 32'h80000000);
        issue(4'h6, 1'b0, 5'd4, 32'h33, 5'd9, 32'h44, 1'b0, 32'h0, 5'd11, 1'b1, 32'h80000000, 32'h44);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.b !== 32'h22) begin
            failures++; $display("FAIL held_before: got vld=%b b=%h, required 1/00000022", bus.out_valid, bus.b);
        end
        @(posedge clk); #1;
        bus.fwd_valid   = 1'b1;
        bus.fwd_rd_addr = 5'd4;
        bus.fwd_data    = 32'h80000000;
        @(posedge clk); #1;
        bus.fwd_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.b !== 32'h80000000 || bus.a !== 32'h11) begin
            failures++; $display("FAIL held_patch: got vld=%b a=%h b=%h, required 1/00000011/80000000", bus.out_valid, bus.a, bus.b);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_imm_zero();
        bus.out_ready   = 1'b0;
        bus.fwd_valid   = 1'b1;
        bus.fwd_rd_addr = 5'd7;
        bus.fwd_data    = 32'h12345678;
        issue(4'hF, 1'b1, 5'd1, 32'd2, 5'd7, 32'd3, 1'b1, 32'hFFFFFFF0, 5'd12, 1'b0, 32'd2, 32'hFFFFFFF0);
        @(negedge clk);
        checks++; if (bus.b !== 32'hFFFFFFF0 || bus.alu_op !== 4'hF || bus.unsigned_flag !== 1'b1) begin
            failures++; $display("FAIL imm_held: got b=%h op=%h uns=%b, required fffffff0/f/1", bus.b, bus.alu_op, bus.unsigned_flag);
        end
        @(posedge clk); #1;
        bus.fwd_rd_addr = 5'd0;
        bus.fwd_data    = 32'd9;
        issue(4'h2, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'h0, 5'd13, 1'b1, 32'd0, 32'd0);
        @(posedge clk); #1;
        bus.fwd_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        issue(4'h7, 1'b0, 5'd1, 32'h71, 5'd2, 32'h72, 1'b0, 32'h0, 5'd14, 1'b1, 32'h71, 32'h72);
        issue(4'h8, 1'b0, 5'd3, 32'h81, 5'd4, 32'h82, 1'b0, 32'h0, 5'd15, 1'b1, 32'h81, 32'h82);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_ctrl: got vld=%b rdy=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.stall_count !== 16'd0 || bus.a !== 32'h0) begin
            failures++; $display("FAIL midreset_clear: got stall=%0d a=%h, required 0/0", bus.stall_count, bus.a);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_leak[%0d]: out_valid=%b, required 0", i, bus.out_valid); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fwd_capture();
        test_fwd_held();
        test_imm_zero();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected results never produced, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
